vector_source: RTL and testbench

Drives the three bit-range-offset vectors `vector0 [1:1]`, `vector1 [8:1]` and `vector2 [20:5]` into a consuming module. It emits bursts of deterministic data: an 8-bit counter, a 16-bit LFSR and a parity bit. Declared index ranges are part of the contract; LSBs are `vector1[1]` and `vector2[5]`. The block serves as the stimulus end of the range-propagation path and exercises non-zero-based port ranges through the hierarchy.

---
 rtl/vector_source_pkg.sv | 24 ++
 rtl/vector_source_if.sv | 27 ++
 rtl/vector_lfsr.sv | 45 ++++
 rtl/vector_source.sv | 104 ++++++++++
 tb/tb_vector_source.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/vector_source_pkg.sv
// Shared definitions for the vector_source stimulus block: FSM states,
// declared vector ranges, LFSR taps and the default seed.
package vector_source_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int VEC1_MSB = 8;
  localparam int VEC1_LSB = 1;
  localparam int VEC2_MSB = 20;
  localparam int VEC2_LSB = 5;

  // Taps of x^16+x^14+x^13+x^11+1 expressed in the [20:5] index space.
  localparam int LFSR_TAP0 = 20;
  localparam int LFSR_TAP1 = 18;
  localparam int LFSR_TAP2 = 17;
  localparam int LFSR_TAP3 = 15;

  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/vector_source_if.sv
// Control inputs and vector outputs between vector_source and its consumer.
interface vector_source_if;
  import vector_source_pkg::*;

  logic                          start;
  logic                          hold;
  logic                          seed_load;
  logic [VEC2_MSB:VEC2_LSB]      seed;
  logic [1:1]                    vector0;
  logic [VEC1_MSB:VEC1_LSB]      vector1;
  logic [VEC2_MSB:VEC2_LSB]      vector2;
  logic                          busy;
  logic                          done;

  // Source side: drives the vectors and status.
  modport master (
    input  start, hold, seed_load, seed,
    output vector0, vector1, vector2, busy, done
  );

  // Consumer/controller side.
  modport slave (
    output start, hold, seed_load, seed,
    input  vector0, vector1, vector2, busy, done
  );

endinterface

// File: rtl/vector_lfsr.sv
// 16-bit Fibonacci LFSR held on the [20:5] range. A zero load value is
// replaced by SEED so the register can never lock up at all-zero.
module vector_lfsr
  import vector_source_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     step_i,
  input  logic                     load_i,
  input  logic [VEC2_MSB:VEC2_LSB] load_value_i,
  output logic [VEC2_MSB:VEC2_LSB] state_o,
  output logic [VEC2_MSB:VEC2_LSB] next_o
);

  logic [VEC2_MSB:VEC2_LSB] state_q;
  logic [VEC2_MSB:VEC2_LSB] state_d;
  logic                     fb;

  // Next LFSR state: load has priority over a shift step.
  always_comb begin
    fb      = state_q[LFSR_TAP0] ^ state_q[LFSR_TAP1] ^
              state_q[LFSR_TAP2] ^ state_q[LFSR_TAP3];
    state_d = state_q;
    if (load_i) begin
      state_d = (load_value_i == '0) ? SEED : load_value_i;
    end else if (step_i) begin
      state_d = {state_q[VEC2_MSB-1:VEC2_LSB], fb};
    end
  end

  // LFSR state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;
  assign next_o  = state_d;

endmodule

// File: rtl/vector_source.sv
// Burst generator driving three offset-range vectors: a beat counter on
// [8:1], an LFSR on [20:5] and their odd parity on [1:1]. All outputs are
// registered; parity is computed from the next-state values so it always
// matches the vectors it accompanies.
module vector_source
  import vector_source_pkg::*;
#(
  parameter int          BURST_LEN = 16,
  parameter logic [15:0] LFSR_SEED = DEFAULT_SEED
) (
  input  logic            clk,
  input  logic            rst,
  vector_source_if.master vs
);

  localparam logic [7:0] BURST_LEN_C = 8'(BURST_LEN);
  localparam logic       VEC0_RST    = ^LFSR_SEED;

  state_e                   state_q, state_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [VEC1_MSB:VEC1_LSB] vec1_q, vec1_d;
  logic [1:1]               vec0_q, vec0_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     lfsr_step;
  logic                     lfsr_load;
  logic [VEC2_MSB:VEC2_LSB] lfsr_state;
  logic [VEC2_MSB:VEC2_LSB] lfsr_next;

  vector_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk          (clk),
    .rst          (rst),
    .step_i       (lfsr_step),
    .load_i       (lfsr_load),
    .load_value_i (vs.seed),
    .state_o      (lfsr_state),
    .next_o       (lfsr_next)
  );

  // Next-state, beat counting and registered-output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    vec1_d    = vec1_q;
    lfsr_step = 1'b0;
    lfsr_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // seed_load wins over start when both are high.
        if (vs.seed_load) begin
          lfsr_load = 1'b1;
        end else if (vs.start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (!vs.hold) begin
          lfsr_step = 1'b1;
          vec1_d    = vec1_q + 8'd1;
          cnt_d     = cnt_q + 8'd1;
          if (cnt_d == BURST_LEN_C) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    vec0_d = ^{vec1_d, lfsr_next};
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      vec1_q  <= '0;
      vec0_q  <= VEC0_RST;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec1_q  <= vec1_d;
      vec0_q  <= vec0_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign vs.vector0 = vec0_q;
  assign vs.vector1 = vec1_q;
  assign vs.vector2 = lfsr_state;
  assign vs.busy    = busy_q;
  assign vs.done    = done_q;

endmodule

// File: tb/tb_vector_source.sv
// Randomised and directed bench for vector_source against a behavioural
// burst model (beats remaining, counter value, polynomial LFSR value).
module tb_vector_source;
  import vector_source_pkg::*;

  localparam int BL = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vector_source_if vif();

  vector_source #(.BURST_LEN(BL), .LFSR_SEED(16'hACE1)) dut (
    .clk (clk),
    .rst (rst),
    .vs  (vif)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model
  int unsigned m_v1;
  logic [15:0] m_v2;
  bit          m_busy;
  bit          m_done;
  int          m_left;
  logic [7:0]  prev_v1;
  bit          saw_wrap;

  function automatic logic [15:0] poly_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic model_reset();
    m_v1 = 0; m_v2 = 16'hACE1; m_busy = 0; m_done = 0; m_left = 0;
  endtask

  task automatic model_step();
    bit nd;
    nd = 0;
    if (!m_done) begin
      if (m_busy) begin
        if (!vif.hold) begin
          m_v1 = (m_v1 + 1) % 256;
          m_v2 = poly_step(m_v2);
          m_left--;
          if (m_left == 0) begin
            m_busy = 0;
            nd = 1;
          end
        end
      end else if (vif.seed_load) begin
        m_v2 = (vif.seed == 16'h0) ? 16'hACE1 : vif.seed;
      end else if (vif.start) begin
        m_busy = 1;
        m_left = BL;
      end
    end
    m_done = nd;
  endtask

  task automatic check_all(input string ctx);
    logic [7:0] e1;
    e1 = m_v1[7:0];
    check({ctx, ".vector1"}, 32'(vif.vector1), 32'(e1));
    check({ctx, ".vector2"}, 32'(vif.vector2), 32'(m_v2));
    check({ctx, ".vector0"}, 32'(vif.vector0), 32'(^{e1, m_v2}));
    check({ctx, ".busy"}, 32'(vif.busy), 32'(m_busy));
    check({ctx, ".done"}, 32'(vif.done), 32'(m_done));
  endtask

  task automatic tick();
    prev_v1 = vif.vector1;
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    check_all("cyc");
    if (prev_v1 == 8'hFF && vif.vector1 != 8'hFF) begin
      saw_wrap = 1;
      check("wrap", 32'(vif.vector1), 32'h0);
    end
  endtask

  // Issues one start pulse and waits (bounded) for done; returns the
  // number of edges from the start edge to the one raising done.
  task automatic run_burst(input int hold_at, input int hold_len,
                           input bit first_chk, output int lat);
    logic [7:0] frozen;
    frozen = 8'h0;
    vif.start = 1; tick(); vif.start = 0;
    lat = 0;
    for (int i = 0; i < 50; i++) begin
      vif.hold = (i >= hold_at && i < hold_at + hold_len);
      if (i == hold_at) frozen = vif.vector1;
      tick();
      lat++;
      if (vif.hold) check("hold_frozen", 32'(vif.vector1), 32'(frozen));
      if (first_chk && i == 0) begin
        check("beat1.vector1", 32'(vif.vector1), 32'h1);
        check("beat1.vector2", 32'(vif.vector2), 32'h59C3);
        check("beat1.vector0", 32'(vif.vector0), 32'h1);
      end
      if (vif.done) break;
    end
    vif.hold = 0;
    tick();
    check("done_pulse_end", 32'(vif.done), 32'h0);
  endtask

  int lat;
  int dones;
  bit busy_seen;

  initial begin
    vif.start = 0; vif.hold = 0; vif.seed_load = 0; vif.seed = '0;
    saw_wrap = 0;
    rst = 1;
    model_reset();
    #2;
    check("rst.vector1", 32'(vif.vector1), 32'h0);
    check("rst.vector2", 32'(vif.vector2), 32'hACE1);
    check("rst.vector0", 32'(vif.vector0), 32'h0);
    check("rst.busy", 32'(vif.busy), 32'h0);
    check("rst.done", 32'(vif.done), 32'h0);
    tick(); tick();
    rst = 0;
    tick();

    // Plain burst from reset state
    run_burst(100, 0, 1, lat);
    check("burst.latency", 32'(lat), 32'(BL));
    check("burst.vector1", 32'(vif.vector1), 32'h4);

    // Burst with three held cycles
    run_burst(1, 3, 0, lat);
    check("hold.latency", 32'(lat), 32'(BL + 3));

    // Seed loading from a clean reset
    rst = 1; tick(); rst = 0; tick();
    vif.seed = 16'h0; vif.seed_load = 1; tick(); vif.seed_load = 0;
    check("seed0.vector2", 32'(vif.vector2), 32'hACE1);
    vif.seed = 16'h0001; vif.seed_load = 1; tick(); vif.seed_load = 0;
    check("seed1.vector2", 32'(vif.vector2), 32'h0001);
    check("seed1.vector0", 32'(vif.vector0), 32'h1);

    // start together with seed_load: seed wins, no burst
    vif.seed = 16'h1234; vif.seed_load = 1; vif.start = 1; tick();
    vif.seed_load = 0; vif.start = 0;
    check("both.busy", 32'(vif.busy), 32'h0);
    check("both.vector2", 32'(vif.vector2), 32'h1234);
    tick();
    check("both.busy_later", 32'(vif.busy), 32'h0);

    // start during RUN and during DONE is ignored
    vif.start = 1; tick(); vif.start = 0;
    tick();
    vif.start = 1; tick(); vif.start = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (vif.done) break;
    end
    check("ignore.done_seen", 32'(vif.done), 32'h1);
    vif.start = 1; tick(); vif.start = 0;
    busy_seen = 0; dones = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (vif.busy) busy_seen = 1;
      if (vif.done) dones++;
    end
    check("ignore.no_second_burst", 32'(busy_seen), 32'h0);
    check("ignore.no_extra_done", 32'(dones), 32'h0);

    // Enough beats to wrap the counter through 8'hFF
    for (int k = 0; k < 70; k++) begin
      run_burst($urandom_range(0, 3), $urandom_range(0, 2), 0, lat);
    end
    check("wrap_seen", 32'(saw_wrap), 32'h1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      vif.start     = ($urandom_range(0, 3) == 0);
      vif.hold      = ($urandom_range(0, 2) == 0);
      vif.seed_load = ($urandom_range(0, 7) == 0);
      vif.seed      = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      tick();
    end
    vif.start = 0; vif.hold = 0; vif.seed_load = 0;
    for (int i = 0; i < 8; i++) tick();

    // Asynchronous reset in the middle of a burst
    vif.start = 1; tick(); vif.start = 0;
    tick(); tick();
    #2;
    rst = 1;
    #1;
    model_reset();
    check("midrst.vector1", 32'(vif.vector1), 32'h0);
    check("midrst.vector2", 32'(vif.vector2), 32'hACE1);
    check("midrst.vector0", 32'(vif.vector0), 32'h0);
    check("midrst.busy", 32'(vif.busy), 32'h0);
    check("midrst.done", 32'(vif.done), 32'h0);
    tick(); tick();
    rst = 0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (vif.done) dones++;
    end
    check("midrst.no_done", 32'(dones), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
